// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit RISC controller:
// FSM states, instruction classes, IR fields and datapath control codes.
package cpu_pkg;

   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned NUM_STATES = 16;
   localparam int unsigned OPC_W      = 3;
   localparam int unsigned OP_W       = 2;
   localparam int unsigned NSEL_W     = 3;
   localparam int unsigned VSEL_W     = 2;

   // IR field positions
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 13;
   localparam int unsigned OP_MSB  = 12;
   localparam int unsigned OP_LSB  = 11;

   localparam logic [OPC_W-1:0] OPC_LDR  = 3'b011;
   localparam logic [OPC_W-1:0] OPC_STR  = 3'b100;
   localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
   localparam logic [OPC_W-1:0] OPC_MOV  = 3'b110;
   localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

   localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
   localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
   localparam logic [OP_W-1:0] OP_AND     = 2'b10;
   localparam logic [OP_W-1:0] OP_MVN     = 2'b11;
   localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
   localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
   localparam logic [OP_W-1:0] OP_MEM     = 2'b00;

   localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
   localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b100;
   localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
   localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b001;

   localparam logic [VSEL_W-1:0] VSEL_C     = 2'b00;
   localparam logic [VSEL_W-1:0] VSEL_IMM   = 2'b10;
   localparam logic [VSEL_W-1:0] VSEL_MDATA = 2'b11;

   typedef enum logic [NUM_STATES-1:0] {
      S_RST     = 16'h0001,
      S_FETCH_A = 16'h0002,
      S_FETCH_L = 16'h0004,
      S_INC     = 16'h0008,
      S_DECODE  = 16'h0010,
      S_WR_IMM  = 16'h0020,
      S_GET_A   = 16'h0040,
      S_GET_B   = 16'h0080,
      S_ALU     = 16'h0100,
      S_WR_RD   = 16'h0200,
      S_ADDR    = 16'h0400,
      S_MEM_RD  = 16'h0800,
      S_LD_WR   = 16'h1000,
      S_ST_B    = 16'h2000,
      S_ST_W    = 16'h4000,
      S_HALT    = 16'h8000
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP, CLS_MOV_IMM, CLS_MOV_REG, CLS_ARITH,
      CLS_CMP, CLS_LDR, CLS_STR, CLS_HALT
   } iclass_t;

   typedef struct packed {
      logic              pcrst;
      logic              loadpc;
      logic              loadir;
      logic              msel;
      logic              mwrite;
      logic [NSEL_W-1:0] nsel;
      logic [VSEL_W-1:0] vsel;
      logic              write;
      logic              loada;
      logic              loadb;
      logic              loadc;
      logic              loads;
      logic              asel;
      logic              bsel;
      logic              halted;
   } ctrl_t;

   // Moore output decode for a state; the ALU state also looks at the class.
   function automatic ctrl_t ctrl_decode(input state_t s, input iclass_t cls);
      ctrl_t c;
      c = '0;
      case (s)
         S_RST:     c.pcrst  = 1'b1;
         S_FETCH_A: c.msel   = 1'b0;
         S_FETCH_L: c.loadir = 1'b1;
         S_INC:     c.loadpc = 1'b1;
         S_WR_IMM: begin
            c.nsel  = NSEL_RN;
            c.vsel  = VSEL_IMM;
            c.write = 1'b1;
         end
         S_GET_A: begin
            c.nsel  = NSEL_RN;
            c.loada = 1'b1;
         end
         S_GET_B: begin
            c.nsel  = NSEL_RM;
            c.loadb = 1'b1;
         end
         S_ALU: begin
            if (cls == CLS_CMP) begin
               c.loads = 1'b1;
            end else begin
               c.loadc = 1'b1;
               c.asel  = (cls == CLS_MOV_REG);
            end
         end
         S_WR_RD: begin
            c.nsel  = NSEL_RD;
            c.vsel  = VSEL_C;
            c.write = 1'b1;
         end
         S_ADDR: begin
            c.bsel  = 1'b1;
            c.loadc = 1'b1;
         end
         S_MEM_RD: c.msel = 1'b1;
         S_LD_WR: begin
            c.msel  = 1'b1;
            c.nsel  = NSEL_RD;
            c.vsel  = VSEL_MDATA;
            c.write = 1'b1;
         end
         S_ST_B: begin
            c.nsel  = NSEL_RD;
            c.loadb = 1'b1;
         end
         S_ST_W: begin
            c.msel   = 1'b1;
            c.mwrite = 1'b1;
         end
         S_HALT:  c.halted = 1'b1;
         default: c.nsel = NSEL_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Controller <-> fetch/datapath bundle: IR in, control strobes out.
interface cpu_control_if;
   import cpu_pkg::*;

   logic [DATA_WIDTH-1:0] ir;
   logic                  pcrst;
   logic                  loadpc;
   logic                  loadir;
   logic                  msel;
   logic                  mwrite;
   logic [NSEL_W-1:0]     nsel;
   logic [VSEL_W-1:0]     vsel;
   logic                  write;
   logic                  loada;
   logic                  loadb;
   logic                  loadc;
   logic                  loads;
   logic                  asel;
   logic                  bsel;
   logic                  halted;

   modport master (
      input  ir,
      output pcrst, loadpc, loadir, msel, mwrite, nsel, vsel, write,
             loada, loadb, loadc, loads, asel, bsel, halted
   );

   modport slave (
      output ir,
      input  pcrst, loadpc, loadir, msel, mwrite, nsel, vsel, write,
             loada, loadb, loadc, loads, asel, bsel, halted
   );
endinterface

// File: rtl/cpu_decode.sv
// Combinational {opcode,op} -> instruction class; unknown codes are NOPs.
module cpu_decode
   import cpu_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   input  logic [OP_W-1:0]  op,
   output iclass_t          cls_c
);

   always_comb begin
      cls_c = CLS_NOP;
      case (opcode)
         OPC_MOV: begin
            if (op == OP_MOV_IMM)      cls_c = CLS_MOV_IMM;
            else if (op == OP_MOV_REG) cls_c = CLS_MOV_REG;
         end
         OPC_ALU: begin
            case (op)
               OP_ADD, OP_AND: cls_c = CLS_ARITH;
               OP_CMP:         cls_c = CLS_CMP;
               OP_MVN:         cls_c = CLS_MOV_REG;
               default:        cls_c = CLS_NOP;
            endcase
         end
         OPC_LDR:  if (op == OP_MEM) cls_c = CLS_LDR;
         OPC_STR:  if (op == OP_MEM) cls_c = CLS_STR;
         OPC_HALT: cls_c = CLS_HALT;
         default:  cls_c = CLS_NOP;
      endcase
   end

endmodule

// File: rtl/cpu_control.sv
// Sequencing FSM for the 16-bit RISC core. Outputs are flops loaded with the
// decode of the next state, so they always equal the current state's decode.
module cpu_control
   import cpu_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   cpu_control_if.master bus
);

   state_t  state, state_nx;
   ctrl_t   ctrl, ctrl_nx;
   iclass_t cls_c;
   logic    unused_ir_c;

   cpu_decode u_decode (
      .opcode (bus.ir[OPC_MSB:OPC_LSB]),
      .op     (bus.ir[OP_MSB:OP_LSB]),
      .cls_c  (cls_c)
   );

   // Register-file fields belong to the datapath
   assign unused_ir_c = ^bus.ir[OP_LSB-1:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_RST;
         ctrl  <= ctrl_decode(S_RST, CLS_NOP);
      end else begin
         state <= state_nx;
         ctrl  <= ctrl_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ctrl_nx  = '0;
      case (state)
         S_RST:     state_nx = S_FETCH_A;
         S_FETCH_A: state_nx = S_FETCH_L;
         S_FETCH_L: state_nx = S_INC;
         S_INC:     state_nx = S_DECODE;
         S_DECODE: begin
            case (cls_c)
               CLS_MOV_IMM:                         state_nx = S_WR_IMM;
               CLS_MOV_REG:                         state_nx = S_GET_B;
               CLS_ARITH, CLS_CMP, CLS_LDR, CLS_STR: state_nx = S_GET_A;
               CLS_HALT:                            state_nx = S_HALT;
               default:                             state_nx = S_FETCH_A;
            endcase
         end
         S_WR_IMM:  state_nx = S_FETCH_A;
         S_GET_A:   state_nx = (cls_c == CLS_LDR || cls_c == CLS_STR) ? S_ADDR : S_GET_B;
         S_GET_B:   state_nx = S_ALU;
         S_ALU:     state_nx = (cls_c == CLS_CMP) ? S_FETCH_A : S_WR_RD;
         S_WR_RD:   state_nx = S_FETCH_A;
         S_ADDR:    state_nx = (cls_c == CLS_LDR) ? S_MEM_RD : S_ST_B;
         S_MEM_RD:  state_nx = S_LD_WR;
         S_LD_WR:   state_nx = S_FETCH_A;
         S_ST_B:    state_nx = S_ST_W;
         S_ST_W:    state_nx = S_FETCH_A;
         S_HALT:    state_nx = S_HALT;
         default:   state_nx = S_RST;
      endcase
      ctrl_nx = ctrl_decode(state_nx, cls_c);
   end

   assign bus.pcrst  = ctrl.pcrst;
   assign bus.loadpc = ctrl.loadpc;
   assign bus.loadir = ctrl.loadir;
   assign bus.msel   = ctrl.msel;
   assign bus.mwrite = ctrl.mwrite;
   assign bus.nsel   = ctrl.nsel;
   assign bus.vsel   = ctrl.vsel;
   assign bus.write  = ctrl.write;
   assign bus.loada  = ctrl.loada;
   assign bus.loadb  = ctrl.loadb;
   assign bus.loadc  = ctrl.loadc;
   assign bus.loads  = ctrl.loads;
   assign bus.asel   = ctrl.asel;
   assign bus.bsel   = ctrl.bsel;
   assign bus.halted = ctrl.halted;

endmodule

// File: tb/tb_cpu_control.sv
// Directed cycle-by-cycle check of the cpu_control output vector.
module tb_cpu_control;

   // Packed view: {pcrst,loadpc,loadir,msel,mwrite,nsel[3],vsel[2],write,
   //               loada,loadb,loadc,loads,asel,bsel,halted}
   localparam logic [17:0] E_RST    = 18'h20000;
   localparam logic [17:0] E_FA     = 18'h00000;
   localparam logic [17:0] E_FL     = 18'h08000;
   localparam logic [17:0] E_INC    = 18'h10000;
   localparam logic [17:0] E_DEC    = 18'h00000;
   localparam logic [17:0] E_WRIMM  = 18'h01280;
   localparam logic [17:0] E_GETA   = 18'h01040;
   localparam logic [17:0] E_GETB   = 18'h00420;
   localparam logic [17:0] E_ALU    = 18'h00010;
   localparam logic [17:0] E_ALUMOV = 18'h00014;
   localparam logic [17:0] E_ALUCMP = 18'h00008;
   localparam logic [17:0] E_WRRD   = 18'h00880;
   localparam logic [17:0] E_ADDR   = 18'h00012;
   localparam logic [17:0] E_MEMRD  = 18'h04000;
   localparam logic [17:0] E_LDWR   = 18'h04B80;
   localparam logic [17:0] E_STB    = 18'h00820;
   localparam logic [17:0] E_STW    = 18'h06000;
   localparam logic [17:0] E_HALT   = 18'h00001;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   cpu_control_if bus ();

   cpu_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] observed();
      return {bus.pcrst, bus.loadpc, bus.loadir, bus.msel, bus.mwrite,
              bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb,
              bus.loadc, bus.loads, bus.asel, bus.bsel, bus.halted};
   endfunction

   task automatic check_eq(input string tag, input logic [17:0] got,
                           input logic [17:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %05h expected %05h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare the whole output vector
   task automatic step(input string tag, input logic [17:0] exp);
      @(negedge clk);
      check_eq(tag, observed(), exp);
   endtask

   initial begin
      reset  = 1'b0;
      bus.ir = 16'hD205;
      step("rst_0", E_RST);
      step("rst_1", E_RST);
      reset = 1'b1;

      // MOV R2,#5 : 5-cycle period
      step("mov_fa", E_FA);
      step("mov_fl", E_FL);
      step("mov_inc", E_INC);
      step("mov_dec", E_DEC);
      step("mov_wrimm", E_WRIMM);
      step("mov_next_fa", E_FA);

      // ADD R3,R1,R2 : 8-cycle period
      bus.ir = 16'hA162;
      step("add_fl", E_FL);
      step("add_inc", E_INC);
      step("add_dec", E_DEC);
      step("add_geta", E_GETA);
      step("add_getb", E_GETB);
      step("add_alu", E_ALU);
      step("add_wrrd", E_WRRD);
      step("add_next_fa", E_FA);

      // MVN : A operand forced to zero, 7-cycle period
      bus.ir = 16'hB820;
      step("mvn_fl", E_FL);
      step("mvn_inc", E_INC);
      step("mvn_dec", E_DEC);
      step("mvn_getb", E_GETB);
      step("mvn_alu", E_ALUMOV);
      step("mvn_wrrd", E_WRRD);
      step("mvn_next_fa", E_FA);

      // CMP R0,R1 : status load only, no loadc/write
      bus.ir = 16'hA801;
      step("cmp_fl", E_FL);
      step("cmp_inc", E_INC);
      step("cmp_dec", E_DEC);
      step("cmp_geta", E_GETA);
      step("cmp_getb", E_GETB);
      step("cmp_alu", E_ALUCMP);
      step("cmp_next_fa", E_FA);

      // STR R2,[R1,#3]
      bus.ir = 16'h8143;
      step("str_fl", E_FL);
      step("str_inc", E_INC);
      step("str_dec", E_DEC);
      step("str_geta", E_GETA);
      step("str_addr", E_ADDR);
      step("str_stb", E_STB);
      step("str_stw", E_STW);
      step("str_next_fa", E_FA);

      // LDR
      bus.ir = 16'h6143;
      step("ldr_fl", E_FL);
      step("ldr_inc", E_INC);
      step("ldr_dec", E_DEC);
      step("ldr_geta", E_GETA);
      step("ldr_addr", E_ADDR);
      step("ldr_memrd", E_MEMRD);
      step("ldr_ldwr", E_LDWR);
      step("ldr_next_fa", E_FA);

      // Unused opcode behaves as a 4-cycle NOP
      bus.ir = 16'h0000;
      step("nop_fl", E_FL);
      step("nop_inc", E_INC);
      step("nop_dec", E_DEC);
      step("nop_next_fa", E_FA);

      // Reset during ST_B must abort the store
      bus.ir = 16'h8143;
      step("rstr_fl", E_FL);
      step("rstr_inc", E_INC);
      step("rstr_dec", E_DEC);
      step("rstr_geta", E_GETA);
      step("rstr_addr", E_ADDR);
      step("rstr_stb", E_STB);
      reset = 1'b0;
      step("rstr_abort", E_RST);
      reset = 1'b1;
      step("rstr_fa", E_FA);

      // HALT holds with no fetch activity
      bus.ir = 16'hE000;
      step("halt_fl", E_FL);
      step("halt_inc", E_INC);
      step("halt_dec", E_DEC);
      for (int i = 0; i < 20; i++) step("halt_hold", E_HALT);
      reset = 1'b0;
      step("halt_rst", E_RST);
      reset = 1'b1;
      step("halt_exit_fa", E_FA);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
